// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipeline delay line: the per-cycle operation
// encoding and the occupancy-count width helper.
package dff_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLR   = 2'd3
  } op_e;

  // CNT_W for a given DEPTH: enough bits to hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit, driven by
// the operation decoded once at the top level.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  op_e              op,
  input  logic [WIDTH-1:0] shift_data,
  input  logic             shift_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its upstream neighbour's pre-edge value and the chain shifts by one place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= RESET_VAL;
      valid <= 1'b0;
    end else begin
      case (op)
        OP_CLR: begin
          data  <= RESET_VAL;
          valid <= 1'b0;
        end
        OP_LOAD: begin
          data  <= load_data;
          valid <= 1'b1;
        end
        OP_SHIFT: begin
          data  <= shift_data;
          valid <= shift_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dff_pipeline.sv
// WIDTH-bit, DEPTH-stage delay line with per-stage valid, clock enable,
// synchronous clear, parallel load and a registered occupancy count.
module dff_pipeline
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      load,
  input  logic [WIDTH-1:0]          d,
  input  logic                      d_valid,
  input  logic [DEPTH*WIDTH-1:0]    load_data,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [DEPTH*WIDTH-1:0]    taps,
  output logic [cnt_w(DEPTH)-1:0]   fill_count,
  output logic                      full
);

  localparam int CNT_W = cnt_w(DEPTH);

  op_e              op;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;

  // NOTE: op gets a default before the priority chain so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    op = OP_HOLD;
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_SHIFT;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] sin;
    logic             vin;

    if (i == 0) begin : g_head
      assign sin = d;
      assign vin = d_valid;
    end else begin : g_body
      assign sin = stage_data[i-1];
      assign vin = stage_valid[i-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .shift_data  (sin),
      .shift_valid (vin),
      .load_data   (load_data[i*WIDTH +: WIDTH]),
      .data        (stage_data[i]),
      .valid       (stage_valid[i])
    );

    assign taps[i*WIDTH +: WIDTH] = stage_data[i];
  end

  // On a shift the count moves by what enters minus what leaves; modular
  // arithmetic in CNT_W bits is exact because the result stays in 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count <= '0;
    end else begin
      case (op)
        OP_CLR:   fill_count <= '0;
        OP_LOAD:  fill_count <= CNT_W'(DEPTH);
        OP_SHIFT: fill_count <= fill_count + CNT_W'(d_valid) - CNT_W'(stage_valid[DEPTH-1]);
        default:  ;
      endcase
    end
  end

  assign q       = stage_data[DEPTH-1];
  assign q_valid = stage_valid[DEPTH-1];
  assign full    = (fill_count == CNT_W'(DEPTH));

endmodule

// File: doc/dff_pipeline.md
# dff_pipeline

Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register chain with per-stage valid tracking, clock enable, synchronous clear, parallel load and a registered occupancy count. It serves as the general-purpose delay line and retiming stage between datapath blocks, replacing hand-instantiated chains of single flip-flops.

## Interface
- WIDTH, 8, data width per stage (>= 1)
- DEPTH, 4, number of stages (>= 1)
- RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset or clear

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  shift enable
- clr  in  1  synchronous clear
- load  in  1  synchronous parallel load of all stages
- d  in  WIDTH  serial input to stage 0
- d_valid  in  1  qualifies d on a shift
- load_data  in  DEPTH*WIDTH  parallel load image; stage i = bits [i*WIDTH +: WIDTH]
- q  out  WIDTH  output of stage DEPTH-1
- q_valid  out  1  valid bit of stage DEPTH-1
- taps  out  DEPTH*WIDTH  all stage contents, same packing as load_data
- fill_count  out  $clog2(DEPTH+1)  number of valid stages
- full  out  1  fill_count == DEPTH

## Operation
- Internal state: stage[0..DEPTH-1] (WIDTH bits each), valid[0..DEPTH-1], fill_count register.
- Per-edge priority: clr > load > en > hold. Exactly one operation per cycle.
- clr: all stages <= RESET_VAL, all valid <= 0, fill_count <= 0.
- load: stage[i] <= load_data slice i, all valid <= 1, fill_count <= DEPTH. d and d_valid are ignored.
- shift (en=1, clr=0, load=0): stage[0] <= d, valid[0] <= d_valid, stage[i] <= stage[i-1], valid[i] <= valid[i-1]. fill_count <= fill_count + d_valid - valid[DEPTH-1], with no wrap because the result stays within 0..DEPTH by construction.
- hold (en=0, clr=0, load=0): all state unchanged.
- Data moves regardless of valid. Invalid stages still carry whatever data was shifted in.
- DEPTH=1: stage 0 is both input and output stage. The count is 0 or 1.

## Timing
- Reset (asserted asynchronously, released synchronously by the environment): q=RESET_VAL, taps=all RESET_VAL, q_valid=0, fill_count=0, full=0, all immediately on rst assertion.
- Reset asserted mid-operation discards all contents and count. The first edge after deassertion behaves as a normal edge.
- All outputs are registered or a direct wiring of registers. There is no combinational input-to-output path.
- Latency: a value presented on d with en=1 at edge k appears on q after edge k+DEPTH-1 when en is held high. Each en=0 cycle adds one cycle.
- load and clr take effect at the edge they are sampled. taps reflects the new state in the following cycle.
- Simultaneous clr+load+en: clr wins. Simultaneous load+en: load wins and the shift is lost.
- full is derived from the registered fill_count and updates in the same cycle as it.

## Structure
- Shared package dff_pkg holds the localparam count-width helper (CNT_W = $clog2(DEPTH+1)) and the operation encoding OP_HOLD, OP_SHIFT, OP_LOAD, OP_CLR. The operation is decoded once per cycle from clr, load and en.
- Sub-module dff_stage: one WIDTH-bit data register plus its valid bit, with asynchronous reset to RESET_VAL/0 and a 2-bit op input. It is instantiated DEPTH times with a generate loop.
- The top level holds the op decode, the fill_count register and the output packing.

## Test plan
- Reset: assert rst mid-cycle with WIDTH=8, DEPTH=4 -> q=0x00, q_valid=0, fill_count=0, full=0 immediately, without waiting for an edge.
- Fill and drain: en=1, feed 0x11,0x22,0x33,0x44 with d_valid=1 -> q=0x11 after edge 4, fill_count counts 1,2,3,4, full=1. Then feed 4 cycles with d_valid=0 -> the count decrements to 0 and q walks 0x22..0x44.
- Stall: hold en=0 for 3 cycles mid-stream -> taps and fill_count are frozen. The output sequence is delayed by exactly 3 cycles.
- Load: load=1 with load_data=0x44332211 -> taps=0x44332211, fill_count=4 next cycle. Then load=1 with en=1 and d=0xAA -> the load wins and 0xAA never appears.
- Clear priority: clr=1, load=1, en=1 together on a full pipe -> all stages =RESET_VAL, fill_count=0. Repeat with RESET_VAL=0x5A -> taps=0x5A5A5A5A.
- DEPTH=1 build: shift in 0x7 with d_valid=1 -> q=0x7, full=1 after one edge. Shift d_valid=0 -> fill_count=0.
